// File: rtl/nand_chk_pkg.sv
// Shared types and the golden model for the NAND stimulus/response checker.
package nand_chk_pkg;

  // Widest gate the golden function can model; WIDTH must not exceed this.
  localparam int NAND_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Reference NAND at full model width; callers mask to their own width.
  function automatic logic [NAND_MAX_W-1:0] nand_ref(input logic [NAND_MAX_W-1:0] a,
                                                     input logic [NAND_MAX_W-1:0] b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_chk_settle_cnt.sv
// Settle-window timer: loaded with SETTLE-1 while a vector is driven, then counts
// down; o_zero marks the last settle cycle.
module nand_chk_settle_cnt #(
  parameter int SETTLE = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_zero
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] r_cnt;

  // Load on DRIVE, otherwise count down and hold at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(SETTLE - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nand_stim_checker.sv
// Exhaustive self-test of a combinational NAND: walks {A,B} through every value,
// samples Y after a settle window and counts mismatching vectors.
// Optional first-failure capture is enabled with the FIRST_FAIL_CAPTURE_EN macro.
// Handshake: start is a level sampled only in IDLE/DONE; done stays high with
// pass/err_count stable until the next accepted start or rst.
module nand_stim_checker
  import nand_chk_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   Y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH-1:0] vec_idx,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_idx,
  output logic [WIDTH-1:0]   fail_y,
`endif
  output state_t             o_state
);

  localparam int VW = 2 * WIDTH;
  localparam logic [ERR_W-1:0]      ERR_MAX = {ERR_W{1'b1}};
  localparam logic [NAND_MAX_W-1:0] W_MASK  = {NAND_MAX_W{1'b1}} >> (NAND_MAX_W - WIDTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [VW:0]       r_vec;      // extra MSB flags "past the last vector"
  logic [VW:0]       w_vec_nxt;
  logic              w_last;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [ERR_W-1:0]  r_err;
  logic              r_pass;
  logic              w_start_run;
  logic              w_load;
  logic              w_in_check;
  logic              w_settle_done;
  logic [NAND_MAX_W-1:0] w_ref;
  logic              w_mis;

  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_vec_nxt   = r_vec + 1'b1;
  assign w_last      = w_vec_nxt[VW];

  // Any differing bit makes the whole vector a single mismatch.
  assign w_ref = nand_ref(NAND_MAX_W'(r_a), NAND_MAX_W'(r_b));
  assign w_mis = ((NAND_MAX_W'(Y) ^ w_ref) & W_MASK) != '0;

  nand_chk_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load),
    .o_zero (w_settle_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settle_done) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (start) w_state_nxt = ST_DRIVE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State decode to status outputs and datapath strobes.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    w_load     = 1'b0;
    w_in_check = 1'b0;
    case (r_state)
      ST_DRIVE:  begin busy = 1'b1; w_load = 1'b1; end
      ST_SETTLE: busy = 1'b1;
      ST_CHECK:  begin busy = 1'b1; w_in_check = 1'b1; end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  // Vector walk, operand registers, error counter and pass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_start_run) begin
        r_vec  <= '0;
        r_err  <= '0;
        r_pass <= 1'b0;
      end
      if (w_load) begin
        r_a <= r_vec[VW-1:WIDTH];
        r_b <= r_vec[WIDTH-1:0];
      end
      if (w_in_check) begin
        if (w_mis && (r_err != ERR_MAX)) r_err <= r_err + 1'b1;
        // Hold on the all-ones vector instead of wrapping when the run ends.
        if (!w_last) r_vec <= w_vec_nxt;
        else         r_pass <= (r_err == '0) && !w_mis;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic             r_fail_valid;
  logic [VW-1:0]    r_fail_idx;
  logic [WIDTH-1:0] r_fail_y;

  // Latch index and Y of the first mismatching vector; later ones are ignored.
  always_ff @(posedge clk) begin
    if (rst || w_start_run) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_y     <= '0;
    end else if (w_in_check && w_mis && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_idx   <= r_vec[VW-1:0];
      r_fail_y     <= Y;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;
  assign fail_y     = r_fail_y;
`endif

  assign A         = r_a;
  assign B         = r_b;
  assign vec_idx   = r_vec[VW-1:0];
  assign err_count = r_err;
  assign pass      = r_pass;
  assign o_state   = r_state;

endmodule
